cpa_arbiter: RTL

CPA_ARBITER -- requirements
Module: cpa_arbiter

---
 rtl/cpa_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cpa_arbiter.sv
// Two-requester front end sharing one 13-bit ripple-carry adder.
// Alternating priority when both request; the result is held in a one-entry output slot.

module cpa (
   input  logic [12:0] i_a,
   input  logic [12:0] i_b,
   output logic [12:0] o_sum
);

   logic [12:0] w_carry;

   assign w_carry[0] = 1'b0;

   // The carry out of the top bit is never formed, so the sum wraps modulo 2^13.
   genvar k;
   generate
      for (k = 0; k < 13; k++) begin : g_fa
         assign o_sum[k] = i_a[k] ^ i_b[k] ^ w_carry[k];
         if (k < 12) begin : g_carry
            assign w_carry[k+1] = (i_a[k] & i_b[k]) | (w_carry[k] & (i_a[k] ^ i_b[k]));
         end
      end
   endgenerate

endmodule

module cpa_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req0_valid,
   input  logic [12:0] i_req0_a,
   input  logic [12:0] i_req0_b,
   output logic        o_req0_ready,
   input  logic        i_req1_valid,
   input  logic [12:0] i_req1_a,
   input  logic [12:0] i_req1_b,
   output logic        o_req1_ready,
   output logic        o_res_valid,
   input  logic        i_res_ready,
   output logic [12:0] o_res_sum,
   output logic        o_res_id,
   output logic [15:0] o_ops_count
);

   logic        r_lastGrant;
   logic        r_resValid;
   logic        r_resId;
   logic [12:0] r_resSum;
   logic [15:0] r_opsCount;

   logic        w_slotFree;
   logic        w_grantValid;
   logic        w_grantIdx;
   logic        w_xfer;
   logic [12:0] w_opA;
   logic [12:0] w_opB;
   logic [12:0] w_sum;

   // With both requesting, the one not granted last time wins.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = 1'b0;
      if (i_req0_valid && i_req1_valid) begin
         w_grantValid = 1'b1;
         w_grantIdx   = ~r_lastGrant;
      end else if (i_req0_valid) begin
         w_grantValid = 1'b1;
         w_grantIdx   = 1'b0;
      end else if (i_req1_valid) begin
         w_grantValid = 1'b1;
         w_grantIdx   = 1'b1;
      end
   end

   assign w_slotFree   = ~r_resValid | i_res_ready;
   assign w_xfer       = rst_n & w_slotFree & w_grantValid;
   assign o_req0_ready = w_xfer & ~w_grantIdx;
   assign o_req1_ready = w_xfer & w_grantIdx;

   assign w_opA = w_grantIdx ? i_req1_a : i_req0_a;
   assign w_opB = w_grantIdx ? i_req1_b : i_req0_b;

   cpa u_cpa (
      .i_a   (w_opA),
      .i_b   (w_opB),
      .o_sum (w_sum)
   );

   // A drain and a new accept in the same cycle reload the slot without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= 1'b1;
         r_resValid  <= 1'b0;
         r_resId     <= 1'b0;
         r_resSum    <= 13'd0;
         r_opsCount  <= 16'd0;
      end else if (w_xfer) begin
         r_lastGrant <= w_grantIdx;
         r_resValid  <= 1'b1;
         r_resId     <= w_grantIdx;
         r_resSum    <= w_sum;
         r_opsCount  <= r_opsCount + 16'd1;
      end else if (i_res_ready) begin
         r_resValid  <= 1'b0;
      end
   end

   assign o_res_valid = r_resValid;
   assign o_res_sum   = r_resSum;
   assign o_res_id    = r_resId;
   assign o_ops_count = r_opsCount;

endmodule
